uinstr_encoder: RTL and testbench
=================================

// Module: uinstr_encoder
// PURPOSE
// - Inverse of the microinstruction decoder. Samples the decoded control strobes, re-packs them into
//   the 16-bit microinstruction word, checks that the strobes are legal, and queues each word with
//   a conflict tag in a first-word-fall-through (FWFT) FIFO.
// - Used for bus-trace capture, for the device-bus debug reader, and for decoder loopback self-test.
// PARAMETERS
// - DEPTH   16  FIFO entries; must be a power of two, >= 2
// - ADDR_W  4   log2(DEPTH)
// PORTS
// - clk           in   1   system clock, rising edge
// - reset         in   1   asynchronous, active-high
// - sample        in   1   capture the current strobes at this clock edge
// - EO_bar        in   1   ALU output disable (high = ALU not driving the bus)
// - PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar  in  1 each  active-low bus-out strobes
// - RO, DO        in   1 each  active-high bus-out strobes
// - RT, PP        in   1 each  T-state reset, PC increment
// - ALU_flags     in   6   ALU function bits {EX,NX,EY,NY,F,NO}
// - MI_bar, II_bar, XI_bar, YI_bar  in  1 each  active-low bus-in strobes
// - RI, DI        in   1 each  active-high bus-in strobes
// - JC, JZ, JGT, JLT  in  1 each  jump condition bits
// - rd_en         in   1   pop the head entry; ignored when empty
// - clr_err       in   1   clear both sticky flags
// - rd_data       out  17  {conflict, uinstr[15:0]} of the head entry; 0 when empty
// - empty, full   out  1 each  FIFO status
// - count         out  ADDR_W+1  entries held, 0..DEPTH
// - err_conflict  out  1   sticky: some pushed word had its conflict bit set
// - err_overflow  out  1   sticky: a sample was dropped because the FIFO was full
// BEHAVIOUR
// - Encoding is combinational from the strobes; "active" means the strobe's asserted polarity.
// - Word bit 15 is EO_bar. Bits 1:0 are always 0.
// - Bits 5:2 are {JC,JZ,JGT,JLT}.
// - EO_bar=0: bits 14:9 are ALU_flags.
//   - Conflict if any bus-out strobe, RT or PP is active.
// - EO_bar=1: bits 14:12 are the bus-out code, taken from the active bus-out strobe:
//   - PO_bar=0, IOH_bar=1, IOL_bar=2, RO=3, XO_bar=4, YO_bar=5, DO=6.
//   - No strobe active gives code 7.
//   - More than one active gives the lowest code and flags a conflict.
//   - Bit 11 is RT, bit 10 is PP, bit 9 is ALU_flags[0].
// - Bits 8:6 are the bus-in code: MI_bar=1, II_bar=2, RI=3, XI_bar=4, YI_bar=5, DI=6.
//   - No strobe active gives code 0.
//   - More than one active gives the lowest code and flags a conflict.
//   - Code 7 is never produced.
// - Push: at a clk edge with sample=1 and space available, {conflict, word} is written at the tail.
//   - Latency: the entry is visible on rd_data and counted in count from that edge onward.
// - Pop: at a clk edge with rd_en=1 and empty=0, the head advances.
//   - rd_data shows the next entry, or 0 if the FIFO is now empty.
// - Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
// - Simultaneous push and pop when empty: the pop is ignored and the push is accepted.
// - Push when full without a pop: the word is dropped, err_overflow is set, FIFO contents unchanged.
// - Pointers wrap modulo DEPTH. full = (count == DEPTH). empty = (count == 0).
// - Sticky flags:
//   - err_conflict is set on the edge that pushes an entry with conflict=1.
//   - clr_err clears both flags.
//   - If a set event and clr_err coincide, the set wins.
// - Reset (async, any time, including mid-push): pointers, count, rd_data and both flags go to 0;
//   empty=1, full=0. Stored entries are discarded.
// TESTING
// - Loopback: drive the decoder with uinstr=16'h8E5C and sample into this block.
//   -> rd_data=17'h08E5C, count=1.
// - ALU word: EO_bar=0, ALU_flags=6'b110101, XI_bar=0, JZ=1, all else inactive, sample.
//   -> rd_data=17'h0_6B10.
// - Conflict: EO_bar=1 with PO_bar=0 and XO_bar=0, no bus-in, sample.
//   -> rd_data=17'h1_8000, err_conflict=1. Then clr_err -> err_conflict=0.
// - Fill DEPTH=16 words 0..15, then push word 16.
//   -> full=1, count=16, err_overflow=1, head still word 0.
//   Pop all 16 -> words 0..15 in order, then empty=1, rd_data=0.
// - With the FIFO full, sample=1 and rd_en=1 in the same cycle -> count stays 16, err_overflow=0.
//   With it empty, the same stimulus -> count=1.
// - Assert reset mid-stream with 5 entries held -> count=0 and empty=1 immediately, before any clk
//   edge; flags=0.

Source files
------------

// File: rtl/uinstr_encoder_if.sv
// uinstr_encoder_if: decoded control strobes in, queued microinstruction words and status out
interface uinstr_encoder_if #(parameter int ADDR_W = 4);
  logic              sample;
  logic              EO_bar, PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar, RO, DO;
  logic              RT, PP;
  logic [5:0]        ALU_flags;
  logic              MI_bar, II_bar, XI_bar, YI_bar, RI, DI;
  logic              JC, JZ, JGT, JLT;
  logic              rd_en, clr_err;
  logic [16:0]       rd_data;
  logic              empty, full;
  logic [ADDR_W:0]   count;
  logic              err_conflict, err_overflow;
  modport master (
    output sample, EO_bar, PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar, RO, DO, RT, PP, ALU_flags,
           MI_bar, II_bar, XI_bar, YI_bar, RI, DI, JC, JZ, JGT, JLT, rd_en, clr_err,
    input  rd_data, empty, full, count, err_conflict, err_overflow
  );
  modport slave (
    input  sample, EO_bar, PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar, RO, DO, RT, PP, ALU_flags,
           MI_bar, II_bar, XI_bar, YI_bar, RI, DI, JC, JZ, JGT, JLT, rd_en, clr_err,
    output rd_data, empty, full, count, err_conflict, err_overflow
  );
endinterface

// File: rtl/uinstr_encoder.sv
// uinstr_encoder: re-packs decoded strobes into 16-bit microinstruction words queued in a FWFT FIFO
module uinstr_encoder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             reset,
  uinstr_encoder_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [6:0]        w_bo;
  logic [5:0]        w_bi;
  logic [2:0]        w_oc, w_ic;
  logic              w_bo_multi, w_bi_multi, w_conflict;
  logic [15:0]       w_word;
  logic              w_full, w_empty, w_push, w_pop;
  logic [16:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic [ADDR_W:0]   r_cnt;
  logic              r_err_conflict, r_err_overflow;
  // active-high views indexed by code (bus-in index k means code k+1)
  assign w_bo = {bus.DO, ~bus.YO_bar, ~bus.XO_bar, bus.RO, ~bus.IOL_bar, ~bus.IOH_bar, ~bus.PO_bar};
  assign w_bi = {bus.DI, ~bus.YI_bar, ~bus.XI_bar, bus.RI, ~bus.II_bar, ~bus.MI_bar};
  assign w_bo_multi = |(w_bo & (w_bo - 7'd1));
  assign w_bi_multi = |(w_bi & (w_bi - 6'd1));
  // lowest active code wins; idle bus-out is 7, idle bus-in is 0
  always_comb begin
    w_oc = 3'd7;
    for (int k = 6; k >= 0; k--) if (w_bo[k]) w_oc = 3'(k);
    w_ic = 3'd0;
    for (int k = 5; k >= 0; k--) if (w_bi[k]) w_ic = 3'(k + 1);
  end
  assign w_conflict = w_bi_multi | (bus.EO_bar ? w_bo_multi : (|w_bo | bus.RT | bus.PP));
  assign w_word = {bus.EO_bar, bus.EO_bar ? {w_oc, bus.RT, bus.PP, bus.ALU_flags[0]} : bus.ALU_flags,
                   w_ic, bus.JC, bus.JZ, bus.JGT, bus.JLT, 2'b00};
  assign w_full  = r_cnt == FULL_CNT;
  assign w_empty = r_cnt == '0;
  assign w_pop   = bus.rd_en & ~w_empty;
  assign w_push  = bus.sample & (~w_full | w_pop);
  assign bus.rd_data      = w_empty ? 17'd0 : r_mem[r_rp];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.count        = r_cnt;
  assign bus.err_conflict = r_err_conflict;
  assign bus.err_overflow = r_err_overflow;
  // storage needs no reset: only entries between the pointers are ever visible
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= {w_conflict, w_word};
  // pointers, occupancy and sticky flags; a set event beats clr_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_cnt          <= '0;
      r_err_conflict <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wp           <= r_wp + ADDR_W'(w_push);
      r_rp           <= r_rp + ADDR_W'(w_pop);
      r_cnt          <= r_cnt + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
      r_err_conflict <= (w_push & w_conflict) | (r_err_conflict & ~bus.clr_err);
      r_err_overflow <= (bus.sample & w_full & ~w_pop) | (r_err_overflow & ~bus.clr_err);
    end
  end
endmodule

// File: tb/tb_uinstr_encoder.sv
// tb_uinstr_encoder: vector table, FIFO corner sequences and randomized run against a queue model
module tb_uinstr_encoder;
  typedef struct packed {
    logic eo_bar, po_bar, ioh_bar, iol_bar, ro, xo_bar, yo_bar, d_o, rt, pp;
    logic [5:0] alu;
    logic mi_bar, ii_bar, ri, xi_bar, yi_bar, di, jc, jz, jgt, jlt;
  } strb_t;
  typedef struct {
    strb_t       s;
    logic [16:0] exp;
    string       name;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  uinstr_encoder_if #(.ADDR_W(4)) bus();
  uinstr_encoder #(.DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [16:0] q[$];
  logic m_ec = 1'b0, m_eo = 1'b0;
  strb_t cur;
  vec_t tbl [7];
  function automatic strb_t idle();
    strb_t s = '0;
    s.eo_bar = 1; s.po_bar = 1; s.ioh_bar = 1; s.iol_bar = 1; s.xo_bar = 1; s.yo_bar = 1;
    s.mi_bar = 1; s.ii_bar = 1; s.xi_bar = 1; s.yi_bar = 1;
    return s;
  endfunction
  function automatic logic [16:0] ref_enc(strb_t s);
    logic [6:0] bo = {s.d_o, ~s.yo_bar, ~s.xo_bar, s.ro, ~s.iol_bar, ~s.ioh_bar, ~s.po_bar};
    logic [5:0] bi = {s.di, ~s.yi_bar, ~s.xi_bar, s.ri, ~s.ii_bar, ~s.mi_bar};
    int oc = 7;
    int ic = 0;
    logic c;
    logic [5:0] hi;
    for (int k = 0; k < 7; k++) if (bo[k] && oc == 7) oc = k;
    for (int k = 0; k < 6; k++) if (bi[k] && ic == 0) ic = k + 1;
    c = $countones(bi) > 1;
    if (s.eo_bar) begin
      c = c | ($countones(bo) > 1);
      hi = {oc[2:0], s.rt, s.pp, s.alu[0]};
    end else begin
      c = c | (bo != 0) | s.rt | s.pp;
      hi = s.alu;
    end
    return {c, s.eo_bar, hi, ic[2:0], s.jc, s.jz, s.jgt, s.jlt, 2'b00};
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic apply(strb_t s);
    cur = s;
    bus.EO_bar = s.eo_bar; bus.PO_bar = s.po_bar; bus.IOH_bar = s.ioh_bar; bus.IOL_bar = s.iol_bar;
    bus.RO = s.ro; bus.XO_bar = s.xo_bar; bus.YO_bar = s.yo_bar; bus.DO = s.d_o;
    bus.RT = s.rt; bus.PP = s.pp; bus.ALU_flags = s.alu;
    bus.MI_bar = s.mi_bar; bus.II_bar = s.ii_bar; bus.RI = s.ri; bus.XI_bar = s.xi_bar;
    bus.YI_bar = s.yi_bar; bus.DI = s.di;
    bus.JC = s.jc; bus.JZ = s.jz; bus.JGT = s.jgt; bus.JLT = s.jlt;
  endtask
  task automatic check_all(string n);
    chk({n, " rd_data"}, 32'(bus.rd_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk({n, " count"}, 32'(bus.count), q.size());
    chk({n, " empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({n, " full"}, 32'(bus.full), 32'(q.size() == 16));
    chk({n, " err_conflict"}, 32'(bus.err_conflict), 32'(m_ec));
    chk({n, " err_overflow"}, 32'(bus.err_overflow), 32'(m_eo));
  endtask
  task automatic cyc(string n);
    logic [16:0] e;
    bit pop, push, ovf;
    @(posedge clk);
    e    = ref_enc(cur);
    pop  = bus.rd_en && q.size() > 0;
    push = bus.sample && (q.size() < 16 || pop);
    ovf  = bus.sample && q.size() == 16 && !pop;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    m_ec = (push && e[16]) || (m_ec && !bus.clr_err);
    m_eo = ovf || (m_eo && !bus.clr_err);
    #1 check_all(n);
  endtask
  task automatic do_reset();
    bus.sample = 0; bus.rd_en = 0; bus.clr_err = 0;
    apply(idle());
    reset = 1;
    #1;
    q.delete(); m_ec = 0; m_eo = 0;
    check_all("reset");
    @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic fill16();
    strb_t s;
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.eo_bar = 0; s.alu = 6'(i + 1);
      apply(s);
      bus.sample = 1;
      cyc("fill");
    end
    bus.sample = 0;
  endtask
  initial begin
    strb_t s;
    logic [25:0] r;
    s = idle(); s.po_bar = 0; s.rt = 1; s.pp = 1; s.alu = 6'b000001; s.mi_bar = 0;
    s.jz = 1; s.jgt = 1; s.jlt = 1;
    tbl[0] = '{s, 17'h08E5C, "loopback"};
    s = idle(); s.eo_bar = 0; s.alu = 6'b110101; s.xi_bar = 0; s.jz = 1;
    tbl[1] = '{s, 17'h06B10, "alu_word"};
    s = idle(); s.po_bar = 0; s.xo_bar = 0;
    tbl[2] = '{s, 17'h18000, "out_conflict"};
    s = idle();
    tbl[3] = '{s, 17'h0F000, "idle_code7"};
    s = idle(); s.eo_bar = 0; s.rt = 1;
    tbl[4] = '{s, 17'h10000, "alu_rt_conflict"};
    s = idle(); s.d_o = 1; s.ii_bar = 0; s.di = 1;
    tbl[5] = '{s, 17'h1E080, "in_conflict"};
    s = idle(); s.yo_bar = 0; s.jc = 1;
    tbl[6] = '{s, 17'h0D020, "yo_jc"};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      apply(tbl[i].s);
      bus.sample = 1;
      cyc(tbl[i].name);
      bus.sample = 0;
      chk({tbl[i].name, " word"}, 32'(bus.rd_data), 32'(tbl[i].exp));
      chk({tbl[i].name, " conflict flag"}, 32'(bus.err_conflict), 32'(tbl[i].exp[16]));
      bus.clr_err = 1;
      cyc("clr_err");
      bus.clr_err = 0;
      chk({tbl[i].name, " cleared"}, 32'(bus.err_conflict), 0);
    end
    do_reset();
    fill16();
    s = idle(); s.eo_bar = 0; s.alu = 6'd17;
    apply(s);
    bus.sample = 1;
    cyc("overflow");
    bus.sample = 0;
    chk("ovf full", 32'(bus.full), 1);
    chk("ovf count", 32'(bus.count), 16);
    chk("ovf flag", 32'(bus.err_overflow), 1);
    chk("ovf head", 32'(bus.rd_data), 32'h200);
    bus.rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      chk("pop order", 32'(bus.rd_data), (i + 1) << 9);
      cyc("pop");
    end
    bus.rd_en = 0;
    chk("drained empty", 32'(bus.empty), 1);
    chk("drained rd_data", 32'(bus.rd_data), 0);
    do_reset();
    fill16();
    bus.sample = 1; bus.rd_en = 1;
    cyc("full push_pop");
    bus.sample = 0; bus.rd_en = 0;
    chk("full push_pop count", 32'(bus.count), 16);
    chk("full push_pop ovf", 32'(bus.err_overflow), 0);
    do_reset();
    bus.sample = 1; bus.rd_en = 1;
    cyc("empty push_pop");
    bus.sample = 0; bus.rd_en = 0;
    chk("empty push_pop count", 32'(bus.count), 1);
    do_reset();
    apply(tbl[2].s);
    bus.sample = 1;
    for (int i = 0; i < 5; i++) cyc("pre_reset");
    bus.sample = 0;
    #2 reset = 1;
    #1;
    chk("async count", 32'(bus.count), 0);
    chk("async empty", 32'(bus.empty), 1);
    chk("async err_conflict", 32'(bus.err_conflict), 0);
    chk("async err_overflow", 32'(bus.err_overflow), 0);
    q.delete(); m_ec = 0; m_eo = 0;
    @(posedge clk);
    #1 reset = 0;
    for (int n = 0; n < 600; n++) begin
      r = 26'($urandom);
      s = r;
      if ($urandom_range(1) == 1) begin
        s = idle();
        s.eo_bar = r[25]; s.alu = r[15:10]; {s.jc, s.jz, s.jgt, s.jlt} = r[3:0];
        case ($urandom_range(3))
          0: s.xo_bar = 0;
          1: s.ri = 1;
          2: s.d_o = 1;
          default: s.yi_bar = 0;
        endcase
      end
      apply(s);
      bus.sample  = $urandom_range(3) != 0;
      bus.rd_en   = n < 300 ? $urandom_range(3) == 0 : $urandom_range(3) != 0;
      bus.clr_err = $urandom_range(15) == 0;
      cyc("random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
